// File: rtl/udp_ddr_wr_sched.sv
// -----------------------------------------------------------------------------
// udp_ddr_wr_sched
//
// Moves UDP payload words from the write-side show-ahead FIFO into DDR through
// the FDMA write channel. The block watches the FIFO fill level and issues
// fixed-length write bursts. It pops one FIFO word for every beat the FDMA
// accepts, and walks the DDR start address around a ring buffer.
//
// Handshake semantics (the whole contract with FIFO and FDMA):
//   - fdma_wareq rises one cycle after a burst is scheduled. It stays high
//     until fdma_wbusy is sampled high, which is the grant.
//   - While the burst is open, every cycle with fdma_wvalid=1 is one accepted
//     beat. fdma_wdata is the FIFO head word in that same cycle.
//   - fifo_re pops the FIFO in the same cycle as the accepted beat, but only
//     if the FIFO is not empty.
//   - The burst closes once the FDMA drops fdma_wbusy after the last beat.
//   - fdma_wvalid outside an open burst is ignored.
//
// Optional build macro: UDP_WR_FLUSH_EN
//   When defined, a residual of fewer than BURST_LEN words that sits
//   untouched for FLUSH_TIMEOUT cycles is written out as a partial burst.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   wr_en           scheduling enable, sampled in IDLE only
//   fifo_dout       FIFO show-ahead head word
//   fifo_empty      FIFO empty flag
//   fifo_rdusedw    FIFO occupancy (words)
//   fifo_re         FIFO pop strobe
//   fdma_waddr      burst start byte address
//   fdma_wareq      burst request
//   fdma_wsize      burst length in words
//   fdma_wbusy      FDMA busy with a write burst
//   fdma_wvalid     FDMA accepts fdma_wdata this cycle
//   fdma_wdata      write data (the FIFO head word)
//   burst_cnt       completed burst count, wraps mod 2^32
//   err_underrun    sticky: beat accepted while FIFO was empty
//   state_dbg       current scheduler state
//                   (0 IDLE, 1 REQ, 2 BURST, 3 DONE)
// -----------------------------------------------------------------------------
module udp_ddr_wr_sched #(
   parameter int          ADDR_WIDTH = 32,
   parameter int          BURST_LEN  = 64,
   parameter logic [31:0] BUF_BASE   = 32'h0000_0000,
   parameter logic [31:0] BUF_BYTES  = 32'h0010_0000
`ifdef UDP_WR_FLUSH_EN
   ,
   parameter int          FLUSH_TIMEOUT = 1024
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [31:0]           fifo_dout,
   input  logic                  fifo_empty,
   input  logic [7:0]            fifo_rdusedw,
   output logic                  fifo_re,
   output logic [ADDR_WIDTH-1:0] fdma_waddr,
   output logic                  fdma_wareq,
   output logic [15:0]           fdma_wsize,
   input  logic                  fdma_wbusy,
   input  logic                  fdma_wvalid,
   output logic [31:0]           fdma_wdata,
   output logic [31:0]           burst_cnt,
   output logic                  err_underrun,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [7:0]            BURST_LVL = 8'(BURST_LEN);
   localparam logic [15:0]           BURST_WDS = 16'(BURST_LEN);
   localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BUF_BASE);
   // Ring arithmetic uses one extra bit so the wrap test cannot overflow.
   localparam logic [ADDR_WIDTH:0]   RING_A    = (ADDR_WIDTH+1)'(BUF_BYTES);

   state_t                state;
   logic [15:0]           beat_cnt;
   logic [ADDR_WIDTH-1:0] offset;
   logic [ADDR_WIDTH:0]   off_next;
   logic                  off_wrap;
   logic                  full_ready;

`ifdef UDP_WR_FLUSH_EN
   localparam int              IDLE_W   = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLUSH_TIMEOUT);

   logic [IDLE_W-1:0] idle_cnt;
   logic              partial_lvl;
   logic              flush_fire;
`endif

   // Show-ahead FIFO: the head word is already valid, so data is passed
   // straight through with no read latency.
   assign fdma_wdata = fifo_dout;
   assign fifo_re    = fdma_wvalid && (state == S_BURST) && !fifo_empty;
   assign state_dbg  = state;

   assign full_ready = wr_en && !fdma_wbusy && (fifo_rdusedw >= BURST_LVL);

   always_comb begin
      off_next = {1'b0, offset} + (ADDR_WIDTH+1)'({fdma_wsize, 2'b00});
`ifdef UDP_WR_FLUSH_EN
      // After a partial burst the offset may be misaligned to full bursts.
      // Wrap early if a full burst would no longer fit before the ring end.
      off_wrap = (off_next + (ADDR_WIDTH+1)'(BURST_LEN * 4)) > RING_A;
`else
      off_wrap = (off_next >= RING_A);
`endif
   end

`ifdef UDP_WR_FLUSH_EN
   assign partial_lvl = (fifo_rdusedw != 8'd0) && (fifo_rdusedw < BURST_LVL);
   assign flush_fire  = partial_lvl && (idle_cnt == IDLE_MAX) && wr_en && !fdma_wbusy;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         fdma_wareq   <= 1'b0;
         fdma_waddr   <= BASE_A;
         fdma_wsize   <= 16'd0;
         beat_cnt     <= 16'd0;
         offset       <= '0;
         burst_cnt    <= 32'd0;
         err_underrun <= 1'b0;
`ifdef UDP_WR_FLUSH_EN
         idle_cnt     <= '0;
`endif
      end else begin
         // The beat still counts on underrun; only the pop is suppressed.
         if ((state == S_BURST) && fdma_wvalid && fifo_empty)
            err_underrun <= 1'b1;

`ifdef UDP_WR_FLUSH_EN
         // Counts idle cycles with a residual below one full burst and
         // saturates at the timeout.
         if ((state == S_IDLE) && partial_lvl) begin
            if (idle_cnt != IDLE_MAX)
               idle_cnt <= idle_cnt + IDLE_W'(1);
         end else begin
            idle_cnt <= '0;
         end
`endif

         case (state)
            S_IDLE: begin
               if (full_ready) begin
                  state      <= S_REQ;
                  fdma_wareq <= 1'b1;
                  fdma_wsize <= BURST_WDS;
                  fdma_waddr <= BASE_A + offset;
               end
`ifdef UDP_WR_FLUSH_EN
               else if (flush_fire) begin
                  state      <= S_REQ;
                  fdma_wareq <= 1'b1;
                  fdma_wsize <= {8'd0, fifo_rdusedw};
                  fdma_waddr <= BASE_A + offset;
               end
`endif
            end

            S_REQ: begin
               if (fdma_wbusy) begin
                  fdma_wareq <= 1'b0;
                  state      <= S_BURST;
               end
            end

            S_BURST: begin
               if (fdma_wvalid) begin
                  if (beat_cnt == fdma_wsize - 16'd1) begin
                     beat_cnt <= 16'd0;
                     state    <= S_DONE;
                  end else begin
                     beat_cnt <= beat_cnt + 16'd1;
                  end
               end
            end

            S_DONE: begin
               if (!fdma_wbusy) begin
                  burst_cnt <= burst_cnt + 32'd1;
                  offset    <= off_wrap ? '0 : off_next[ADDR_WIDTH-1:0];
                  state     <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_ddr_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_udp_ddr_wr_sched
//
// Bench for udp_ddr_wr_sched. It contains a queue-based FIFO environment, an
// FDMA responder with random grant, beat and tail timing, and a
// transaction-level reference model:
//   - a request is due one cycle after the scheduler is free with enough
//     words queued;
//   - addresses step by BURST_LEN*4 modulo the ring size;
//   - data leaves in write order;
//   - the burst count rises once per closed burst.
// The ring is shrunk to two bursts so that wrap-around happens often.
// -----------------------------------------------------------------------------
module tb_udp_ddr_wr_sched;

   localparam int          BURST_LEN = 64;
   localparam logic [31:0] BUF_BASE  = 32'h0000_1000;
   localparam logic [31:0] BUF_BYTES = 32'h0000_0200;

   // ---------------- clock / reset / DUT ----------------
   logic        clk, rst, wr_en;
   logic [31:0] fifo_dout;
   logic        fifo_empty;
   logic [7:0]  fifo_rdusedw;
   logic        fifo_re;
   logic [31:0] fdma_waddr;
   logic        fdma_wareq;
   logic [15:0] fdma_wsize;
   logic        fdma_wbusy, fdma_wvalid;
   logic [31:0] fdma_wdata, burst_cnt;
   logic        err_underrun;
   logic [1:0]  state_dbg;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   udp_ddr_wr_sched #(
      .ADDR_WIDTH (32),
      .BURST_LEN  (BURST_LEN),
      .BUF_BASE   (BUF_BASE),
      .BUF_BYTES  (BUF_BYTES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .fifo_dout    (fifo_dout),
      .fifo_empty   (fifo_empty),
      .fifo_rdusedw (fifo_rdusedw),
      .fifo_re      (fifo_re),
      .fdma_waddr   (fdma_waddr),
      .fdma_wareq   (fdma_wareq),
      .fdma_wsize   (fdma_wsize),
      .fdma_wbusy   (fdma_wbusy),
      .fdma_wvalid  (fdma_wvalid),
      .fdma_wdata   (fdma_wdata),
      .burst_cnt    (burst_cnt),
      .err_underrun (err_underrun),
      .state_dbg    (state_dbg)
   );

   // ---------------- environment + model state ----------------
   int          n_checks = 0;
   int          n_errors = 0;

   logic [31:0] fifo_q[$];   // words physically held by the FIFO
   logic [31:0] exp_q[$];    // scoreboard: words still owed to DDR
   logic [31:0] stale;       // head word left showing after the last pop

   // stimulus knobs
   int push_pct, valid_pct, stray_pct, busy_pct, grant_fix, lie_level;
   bit rand_wr_en;

   // reference model
   bit          free;        // scheduler has no burst in flight
   bit          exp_wareq;
   bit          exp_err;
   logic [31:0] exp_burst_cnt;
   logic [31:0] exp_off;
   logic [31:0] exp_addr;

   // FDMA responder
   int f_phase;   // 0 idle, 1 grant wait, 2 beats, 3 tail
   int f_dly, f_left, beats_in_burst, pops;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic reset_dut();
      rst          = 1'b1;
      wr_en        = 1'b0;
      fifo_dout    = 32'd0;
      fifo_empty   = 1'b1;
      fifo_rdusedw = 8'd0;
      fdma_wbusy   = 1'b0;
      fdma_wvalid  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_wareq",     fdma_wareq,   0);
      check("rst_waddr",     fdma_waddr,   BUF_BASE);
      check("rst_wsize",     fdma_wsize,   0);
      check("rst_burst_cnt", burst_cnt,    0);
      check("rst_err",       err_underrun, 0);
      check("rst_state",     state_dbg,    0);
      check("rst_fifo_re",   fifo_re,      0);
      fifo_q.delete();
      exp_q.delete();
      stale          = 32'd0;
      free           = 1'b1;
      exp_wareq      = 1'b0;
      exp_err        = 1'b0;
      exp_burst_cnt  = 32'd0;
      exp_off        = 32'd0;
      exp_addr       = 32'd0;
      f_phase        = 0;
      f_dly          = 0;
      f_left         = 0;
      beats_in_burst = 0;
      pops           = 0;
      lie_level      = -1;
      rst            = 1'b0;
      #1;
   endtask

   task automatic preload(input int n, input bit seq);
      logic [31:0] w;
      for (int i = 0; i < n; i++) begin
         w = seq ? 32'(i) : $urandom;
         fifo_q.push_back(w);
         exp_q.push_back(w);
      end
   endtask

   // One clock cycle. On entry the bench sits just after a rising edge.
   task automatic cycle();
      bit          beat, push, busy, valid, next_wareq, next_err, done_now, in_beats, re_seen;
      int          size, lvl;
      logic [31:0] wd, expw;

      // registered outputs from the last edge
      check("wareq",     fdma_wareq,   exp_wareq);
      check("burst_cnt", burst_cnt,    exp_burst_cnt);
      check("err",       err_underrun, exp_err);

      if (rand_wr_en && ($urandom_range(1, 100) <= 3))
         wr_en = ($urandom_range(0, 4) != 0);

      size       = fifo_q.size();
      lvl        = (lie_level >= 0) ? lie_level : size;
      beat       = 1'b0;
      busy       = 1'b0;
      valid      = 1'b0;
      done_now   = 1'b0;
      next_wareq = exp_wareq;
      next_err   = 1'b0;

      // FDMA responder
      if (f_phase == 0 && fdma_wareq) begin
         check("waddr", fdma_waddr, exp_addr);
         check("wsize", fdma_wsize, BURST_LEN);
         f_dly   = (grant_fix >= 0) ? grant_fix : int'($urandom_range(0, 3));
         f_phase = 1;
      end
      in_beats = (f_phase == 2);
      case (f_phase)
         1: begin
            if (f_dly == 0) begin
               busy    = 1'b1;
               f_phase = 2;
               f_left  = BURST_LEN;
            end else begin
               f_dly--;
            end
         end
         2: begin
            busy = 1'b1;
            if ($urandom_range(1, 100) <= valid_pct) begin
               valid = 1'b1;
               beat  = 1'b1;
               f_left--;
               if (f_left == 0) begin
                  f_phase = 3;
                  f_dly   = $urandom_range(0, 3);
               end
            end
         end
         3: begin
            if (f_dly > 0) begin
               busy = 1'b1;
               f_dly--;
            end else begin
               f_phase  = 0;
               done_now = 1'b1;
            end
         end
         default: begin
            // FDMA occasionally busy with some other master's traffic
            if (!fdma_wareq && ($urandom_range(1, 100) <= busy_pct))
               busy = 1'b1;
         end
      endcase
      if (!in_beats && ($urandom_range(1, 100) <= stray_pct))
         valid = 1'b1;

      // request due: scheduler free, enabled, channel idle, a full burst queued
      if (free && wr_en && !busy && lvl >= BURST_LEN) begin
         next_wareq = 1'b1;
         free       = 1'b0;
         exp_addr   = BUF_BASE + exp_off;
      end
      if (exp_wareq && busy)
         next_wareq = 1'b0;

      push = (size < 128) && ($urandom_range(1, 100) <= push_pct);
      wd   = $urandom;

      fifo_dout    = (size > 0) ? fifo_q[0] : stale;
      fifo_empty   = (size == 0);
      fifo_rdusedw = 8'(lvl);
      fdma_wbusy   = busy;
      fdma_wvalid  = valid;
      #1;

      check("fifo_re", fifo_re, beat && (size > 0));
      if (beat) begin
         beats_in_burst++;
         if (size > 0 && exp_q.size() > 0) begin
            expw = exp_q.pop_front();
            check("wdata", fdma_wdata, expw);
         end else begin
            check("wdata_stale", fdma_wdata, stale);
            next_err = 1'b1;
         end
      end
      re_seen = fifo_re;

      @(posedge clk);
      if (re_seen && fifo_q.size() > 0) begin
         stale = fifo_q.pop_front();
         pops++;
      end
      if (push) begin
         fifo_q.push_back(wd);
         exp_q.push_back(wd);
      end
      if (next_wareq && !exp_wareq)
         lie_level = -1;
      if (done_now) begin
         exp_burst_cnt  = exp_burst_cnt + 32'd1;
         exp_off        = (exp_off + 32'(BURST_LEN * 4)) % BUF_BYTES;
         free           = 1'b1;
         beats_in_burst = 0;
      end
      exp_wareq = next_wareq;
      exp_err   = exp_err | next_err;
      #1;
   endtask

   task automatic set_knobs(input int p, input int v, input int s, input int b, input int g);
      push_pct   = p;
      valid_pct  = v;
      stray_pct  = s;
      busy_pct   = b;
      grant_fix  = g;
      rand_wr_en = 1'b0;
   endtask

   task automatic run_until_bursts(input int n, input int budget, input string tag);
      int  k;
      bit  reached;
      k = 0;
      while (exp_burst_cnt < 32'(n) && k < budget) begin
         cycle();
         k++;
      end
      reached = (exp_burst_cnt >= 32'(n));
      check(tag, reached, 1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      bit hit;
      int k;

      // Full burst: 64 sequential words, grant two cycles after request,
      // continuous beats.
      set_knobs(0, 100, 0, 0, 2);
      reset_dut();
      preload(64, 1'b1);
      wr_en = 1'b1;
      run_until_bursts(1, 300, "full_burst_done");
      repeat (4) cycle();
      check("full_pops",       pops,          64);
      check("full_fifo_empty", fifo_q.size(), 0);
      check("full_state_idle", state_dbg,     0);

      // Below threshold: 63 words never trigger a request.
      set_knobs(0, 100, 5, 0, -1);
      reset_dut();
      preload(63, 1'b0);
      wr_en = 1'b1;
      repeat (5000) cycle();
      check("below_level", fifo_q.size(), 63);
      check("below_pops",  pops,          0);

      // Randomised streaming with ring wrap, random FDMA timing, stray
      // wvalid and wr_en toggling.
      set_knobs(60, 70, 10, 5, -1);
      rand_wr_en = 1'b1;
      reset_dut();
      wr_en = 1'b1;
      repeat (8000) cycle();
      check("stream_progress", (exp_burst_cnt >= 32'd4), 1);

      // Underrun: the FIFO reports 64 but holds 60; the FDMA takes 64 beats.
      set_knobs(0, 100, 30, 0, 1);
      reset_dut();
      preload(60, 1'b1);
      lie_level = 64;
      wr_en     = 1'b1;
      run_until_bursts(1, 300, "underrun_done");
      wr_en = 1'b0;
      repeat (20) cycle();
      check("underrun_pops", pops,         60);
      check("underrun_err",  err_underrun, 1);

      // Reset 20 beats into the second burst
      // (address BUF_BASE + 0x100 at that point).
      set_knobs(0, 100, 0, 0, 0);
      reset_dut();
      preload(128, 1'b0);
      wr_en = 1'b1;
      k   = 0;
      hit = 1'b0;
      while (!hit && k < 400) begin
         cycle();
         k++;
         hit = (exp_burst_cnt == 32'd1) && (beats_in_burst == 20);
      end
      check("mid_burst_reached", hit, 1);
      check("mid_waddr",         fdma_waddr, BUF_BASE + 32'h100);
      rst = 1'b1;
      #1;
      check("mrst_wareq",     fdma_wareq, 0);
      check("mrst_state",     state_dbg,  0);
      check("mrst_waddr",     fdma_waddr, BUF_BASE);
      check("mrst_burst_cnt", burst_cnt,  0);
      check("mrst_fifo_re",   fifo_re,    0);
      @(posedge clk);
      #1;
      check("mrst_wareq_hold", fdma_wareq, 0);
      check("mrst_state_hold", state_dbg,  0);

      // After reset the ring offset restarts at the base address.
      reset_dut();
      preload(64, 1'b1);
      wr_en = 1'b1;
      run_until_bursts(1, 300, "post_reset_done");
      repeat (3) cycle();
      check("post_reset_pops", pops, 64);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
